// File: rtl/proc_debug_pkg.sv
// Shared types and default parameter values for the processor debug controller.
package proc_debug_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } dbg_state_e;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_TRACE_DEPTH = 16;
    localparam int DEF_NUM_BP      = 2;

endpackage

// File: rtl/proc_debug_trace_fifo.sv
// First-word-fall-through trace FIFO with a sticky overflow flag.
// A push while full is dropped unless a pop happens in the same cycle;
// a pop while empty is ignored, even if a push arrives alongside it.
module trace_fifo #(
    parameter int  WIDTH = 64,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full_o,
    output logic [AW:0]      count_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW:0]      count_q;
    logic             overflow_q;
    logic             do_push;
    logic             do_pop;

    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign valid_o    = (count_q != '0);
    assign do_pop     = pop_i && valid_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign data_o     = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

    // Storage array: contents need no reset, the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            if (push_i && !do_push) overflow_q <= 1'b1;
        end
    end

endmodule

// File: rtl/proc_debug_ctrl.sv
// Processor debug controller: halt/run/single-step sequencing, PC
// breakpoints and an instruction trace buffer.
// Optional feature macro: PROC_DEBUG_BREAKPOINT_EN enables the breakpoint
// table; without it the bp_wr_* inputs are ignored and bp_hit stays 0.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_HALT | processor stalled, waiting for step_req or run_req
// ST_RUN  | free running until halt_req, run_req low or breakpoint
// ST_STEP | one cycle of execution, then back to ST_HALT
module proc_debug_ctrl
    import proc_debug_pkg::*;
#(
    parameter int  DATA_W      = DEF_DATA_W,
    parameter int  TRACE_DEPTH = DEF_TRACE_DEPTH,
    parameter int  NUM_BP      = DEF_NUM_BP,
    localparam int BP_IDX_W    = (NUM_BP > 1) ? $clog2(NUM_BP) : 1,
    localparam int CNT_W       = $clog2(TRACE_DEPTH) + 1
) (
    input  logic                CLOCK_50,
    input  logic                Reset,
    input  logic                run_req,
    input  logic                step_req,
    input  logic                halt_req,
    input  logic [DATA_W-1:0]   pc_in,
    input  logic [DATA_W-1:0]   instr_in,
    input  logic                bp_wr_en,
    input  logic [BP_IDX_W-1:0] bp_wr_idx,
    input  logic [DATA_W-1:0]   bp_wr_addr,
    input  logic                bp_wr_valid,
    output logic                cpu_run,
    output logic                halted,
    output logic                bp_hit,
    input  logic                trace_rd,
    output logic [2*DATA_W-1:0] trace_data,
    output logic                trace_valid,
    output logic                trace_full,
    output logic [CNT_W-1:0]    trace_count,
    output logic                trace_overflow
);

    dbg_state_e state_q;
    dbg_state_e state_d;
    logic       bp_stop;

`ifdef PROC_DEBUG_BREAKPOINT_EN
    logic [NUM_BP-1:0] bp_valid_q;
    logic [DATA_W-1:0] bp_addr_q [NUM_BP];
    logic              bp_match;
    logic              skip_q;

    // Breakpoint table; a write becomes visible to the comparators next cycle.
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            bp_valid_q <= '0;
            for (int i = 0; i < NUM_BP; i++) bp_addr_q[i] <= '0;
        end else if (bp_wr_en && (int'(bp_wr_idx) < NUM_BP)) begin
            bp_valid_q[bp_wr_idx] <= bp_wr_valid;
            bp_addr_q[bp_wr_idx]  <= bp_wr_addr;
        end
    end

    // Any valid slot equal to the current PC is a match.
    always_comb begin
        bp_match = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_valid_q[i] && (bp_addr_q[i] == pc_in)) bp_match = 1'b1;
        end
    end

    // Skip flag marks the first RUN cycle so resuming from a breakpoint PC advances.
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) skip_q <= 1'b0;
        else       skip_q <= (state_q != ST_RUN) && (state_d == ST_RUN);
    end

    assign bp_stop = (state_q == ST_RUN) && bp_match && !skip_q;
`else
    logic unused_bp_wr;
    assign unused_bp_wr = ^{bp_wr_en, bp_wr_idx, bp_wr_addr, bp_wr_valid};
    assign bp_stop      = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) state_q <= ST_HALT;
        else       state_q <= state_d;
    end

    // Next-state logic; halt_req outranks step_req, which outranks run_req.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HALT: begin
                if (halt_req)      state_d = ST_HALT;
                else if (step_req) state_d = ST_STEP;
                else if (run_req)  state_d = ST_RUN;
            end
            ST_RUN: begin
                if (halt_req || !run_req || bp_stop) state_d = ST_HALT;
            end
            ST_STEP: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
    end

    // Reset gates cpu_run directly so it drops in the same cycle it is asserted.
    assign cpu_run = !Reset &&
                     (((state_q == ST_RUN) && !bp_stop) || (state_q == ST_STEP));
    assign halted  = (state_q == ST_HALT);
    assign bp_hit  = bp_stop;

    trace_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk_i      (CLOCK_50),
        .rst_i      (Reset),
        .push_i     (cpu_run),
        .pop_i      (trace_rd),
        .data_i     ({pc_in, instr_in}),
        .data_o     (trace_data),
        .valid_o    (trace_valid),
        .full_o     (trace_full),
        .count_o    (trace_count),
        .overflow_o (trace_overflow)
    );

endmodule

// File: tb/tb_proc_debug_ctrl.sv
// Directed testbench for proc_debug_ctrl (default parameters).
module tb_proc_debug_ctrl;

    logic        CLOCK_50;
    logic        Reset;
    logic        run_req;
    logic        step_req;
    logic        halt_req;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        bp_wr_en;
    logic [0:0]  bp_wr_idx;
    logic [31:0] bp_wr_addr;
    logic        bp_wr_valid;
    logic        cpu_run;
    logic        halted;
    logic        bp_hit;
    logic        trace_rd;
    logic [63:0] trace_data;
    logic        trace_valid;
    logic        trace_full;
    logic [4:0]  trace_count;
    logic        trace_overflow;

    int tests = 0;
    int fails = 0;

    proc_debug_ctrl dut (
        .CLOCK_50       (CLOCK_50),
        .Reset          (Reset),
        .run_req        (run_req),
        .step_req       (step_req),
        .halt_req       (halt_req),
        .pc_in          (pc_in),
        .instr_in       (instr_in),
        .bp_wr_en       (bp_wr_en),
        .bp_wr_idx      (bp_wr_idx),
        .bp_wr_addr     (bp_wr_addr),
        .bp_wr_valid    (bp_wr_valid),
        .cpu_run        (cpu_run),
        .halted         (halted),
        .bp_hit         (bp_hit),
        .trace_rd       (trace_rd),
        .trace_data     (trace_data),
        .trace_valid    (trace_valid),
        .trace_full     (trace_full),
        .trace_count    (trace_count),
        .trace_overflow (trace_overflow)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'hC0DE_0000 | pc;
    endfunction

    task automatic step_clk();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic set_pc(input logic [31:0] pc);
        pc_in    = pc;
        instr_in = instr_of(pc);
    endtask

    task automatic test_reset();
        Reset = 1'b1; run_req = 1'b1;
        #2;
        tests++; if (halted !== 1'b1) begin fails++; $display("FAIL reset_halted got %b want 1", halted); end
        tests++; if (cpu_run !== 1'b0) begin fails++; $display("FAIL reset_cpu_run got %b want 0", cpu_run); end
        tests++; if (bp_hit !== 1'b0) begin fails++; $display("FAIL reset_bp_hit got %b want 0", bp_hit); end
        tests++; if ({trace_valid, trace_full, trace_overflow} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {trace_valid, trace_full, trace_overflow}); end
        tests++; if (trace_count !== 5'd0) begin fails++; $display("FAIL reset_count got %0d want 0", trace_count); end
        step_clk();
        tests++; if (cpu_run !== 1'b0) begin fails++; $display("FAIL reset_held_run got %b want 0", cpu_run); end
        run_req = 1'b0;
        Reset   = 1'b0;
    endtask

    task automatic test_run_trace();
        run_req = 1'b1; set_pc(32'd0);
        #1;
        tests++; if (cpu_run !== 1'b0) begin fails++; $display("FAIL run_first_cycle got %b want 0", cpu_run); end
        step_clk();
        for (int i = 0; i < 5; i++) begin
            set_pc(32'(4*i));
            if (i == 4) run_req = 1'b0;
            #1;
            tests++; if (cpu_run !== 1'b1) begin fails++; $display("FAIL run_cycle%0d got %b want 1", i, cpu_run); end
            step_clk();
        end
        #1;
        tests++; if (halted !== 1'b1) begin fails++; $display("FAIL run_stop_halted got %b want 1", halted); end
        tests++; if (cpu_run !== 1'b0) begin fails++; $display("FAIL run_stop_cpu_run got %b want 0", cpu_run); end
        tests++; if (trace_count !== 5'd5) begin fails++; $display("FAIL run_count got %0d want 5", trace_count); end
        for (int i = 0; i < 5; i++) begin
            trace_rd = 1'b1;
            #1;
            tests++; if (trace_data !== {32'(4*i), instr_of(32'(4*i))}) begin fails++; $display("FAIL run_read%0d got %h want %h", i, trace_data, {32'(4*i), instr_of(32'(4*i))}); end
            step_clk();
        end
        #1;
        tests++; if ({trace_valid, trace_count} !== 6'd0) begin fails++; $display("FAIL run_drained got %b/%0d want 0/0", trace_valid, trace_count); end
        step_clk();
        trace_rd = 1'b0;
        #1;
        tests++; if (trace_count !== 5'd0) begin fails++; $display("FAIL empty_read_count got %0d want 0", trace_count); end
    endtask

    task automatic test_step();
        step_req = 1'b1; set_pc(32'h100);
        #1;
        tests++; if (cpu_run !== 1'b0) begin fails++; $display("FAIL step_req_cycle got %b want 0", cpu_run); end
        step_clk();
        step_req = 1'b0;
        #1;
        tests++; if ({cpu_run, halted} !== 2'b10) begin fails++; $display("FAIL step_exec got %b want 10", {cpu_run, halted}); end
        step_clk();
        set_pc(32'h104);
        #1;
        tests++; if ({cpu_run, halted} !== 2'b01) begin fails++; $display("FAIL step_end got %b want 01", {cpu_run, halted}); end
        tests++; if (trace_count !== 5'd1) begin fails++; $display("FAIL step_count got %0d want 1", trace_count); end
        tests++; if (trace_data !== {32'h100, instr_of(32'h100)}) begin fails++; $display("FAIL step_data got %h want %h", trace_data, {32'h100, instr_of(32'h100)}); end
        trace_rd = 1'b1;
        step_clk();
        trace_rd = 1'b0;
        step_req = 1'b1; halt_req = 1'b1;
        step_clk();
        step_req = 1'b0; halt_req = 1'b0;
        #1;
        tests++; if ({cpu_run, halted} !== 2'b01) begin fails++; $display("FAIL step_vs_halt got %b want 01", {cpu_run, halted}); end
        step_clk();
        tests++; if (trace_count !== 5'd0) begin fails++; $display("FAIL step_vs_halt_count got %0d want 0", trace_count); end
    endtask

    task automatic test_full();
        logic [31:0] epc;
        run_req = 1'b1; set_pc(32'd0);
        step_clk();
        for (int i = 0; i < 17; i++) begin
            set_pc(32'(4*i));
            if (i == 16) run_req = 1'b0;
            step_clk();
        end
        tests++; if (trace_count !== 5'd16) begin fails++; $display("FAIL full_count got %0d want 16", trace_count); end
        tests++; if ({trace_full, trace_overflow} !== 2'b11) begin fails++; $display("FAIL full_flags got %b want 11", {trace_full, trace_overflow}); end
        tests++; if (trace_data !== {32'd0, instr_of(32'd0)}) begin fails++; $display("FAIL full_head got %h want %h", trace_data, {32'd0, instr_of(32'd0)}); end
        step_req = 1'b1;
        step_clk();
        step_req = 1'b0; trace_rd = 1'b1; set_pc(32'h200);
        #1;
        tests++; if (cpu_run !== 1'b1) begin fails++; $display("FAIL full_step_run got %b want 1", cpu_run); end
        step_clk();
        trace_rd = 1'b0;
        tests++; if ({trace_count, trace_full, trace_overflow} !== {5'd16, 2'b11}) begin fails++; $display("FAIL full_pushpop got %0d/%b want 16/11", trace_count, {trace_full, trace_overflow}); end
        for (int k = 0; k < 16; k++) begin
            epc = (k < 15) ? 32'(4*(k+1)) : 32'h200;
            trace_rd = 1'b1;
            #1;
            tests++; if (trace_data !== {epc, instr_of(epc)}) begin fails++; $display("FAIL full_drain%0d got %h want %h", k, trace_data, {epc, instr_of(epc)}); end
            step_clk();
        end
        trace_rd = 1'b0;
        tests++; if ({trace_count, trace_overflow} !== {5'd0, 1'b1}) begin fails++; $display("FAIL full_after_drain got %0d/%b want 0/1", trace_count, trace_overflow); end
    endtask

    task automatic test_reset_mid_run();
        bp_wr_en = 1'b1; bp_wr_idx = 1'b0; bp_wr_addr = 32'h40; bp_wr_valid = 1'b1;
        step_clk();
        bp_wr_en = 1'b0;
        run_req = 1'b1;
        step_clk();
        for (int i = 0; i < 7; i++) begin
            set_pc(32'(4*i));
            step_clk();
        end
        set_pc(32'd28);
        #1;
        tests++; if ({cpu_run, trace_count} !== {1'b1, 5'd7}) begin fails++; $display("FAIL mid_pre got %b/%0d want 1/7", cpu_run, trace_count); end
        Reset = 1'b1;
        #1;
        tests++; if (cpu_run !== 1'b0) begin fails++; $display("FAIL mid_cpu_run got %b want 0", cpu_run); end
        tests++; if ({trace_count, trace_valid, trace_overflow, halted} !== {5'd0, 3'b001}) begin fails++; $display("FAIL mid_state got %0d/%b want 0/001", trace_count, {trace_valid, trace_overflow, halted}); end
        step_clk();
        run_req = 1'b0; Reset = 1'b0;
        run_req = 1'b1;
        step_clk();
        for (int i = 0; i < 4; i++) begin
            set_pc(32'h38 + 32'(4*i));
            if (i == 3) run_req = 1'b0;
            #1;
            tests++; if ({cpu_run, bp_hit} !== 2'b10) begin fails++; $display("FAIL mid_bp_cleared%0d got %b want 10", i, {cpu_run, bp_hit}); end
            step_clk();
        end
        trace_rd = 1'b1;
        repeat (4) step_clk();
        trace_rd = 1'b0;
        tests++; if (trace_count !== 5'd0) begin fails++; $display("FAIL mid_flush got %0d want 0", trace_count); end
    endtask

    task automatic test_breakpoint();
        bp_wr_en = 1'b1; bp_wr_idx = 1'b0; bp_wr_addr = 32'h10; bp_wr_valid = 1'b1;
        step_clk();
        bp_wr_en = 1'b0;
        run_req = 1'b1;
        step_clk();
        for (int i = 0; i < 4; i++) begin
            set_pc(32'(4*i));
            #1;
            tests++; if ({cpu_run, bp_hit} !== 2'b10) begin fails++; $display("FAIL bp_pre%0d got %b want 10", i, {cpu_run, bp_hit}); end
            step_clk();
        end
        set_pc(32'h10);
        #1;
`ifdef PROC_DEBUG_BREAKPOINT_EN
        tests++; if ({cpu_run, bp_hit} !== 2'b01) begin fails++; $display("FAIL bp_stop got %b want 01", {cpu_run, bp_hit}); end
        step_clk();
        run_req = 1'b0;
        #1;
        tests++; if ({halted, cpu_run, bp_hit} !== 3'b100) begin fails++; $display("FAIL bp_halted got %b want 100", {halted, cpu_run, bp_hit}); end
        step_clk();
        run_req = 1'b1;
        step_clk();
        #1;
        tests++; if ({cpu_run, bp_hit} !== 2'b10) begin fails++; $display("FAIL bp_skip got %b want 10", {cpu_run, bp_hit}); end
`else
        tests++; if ({cpu_run, bp_hit} !== 2'b10) begin fails++; $display("FAIL bp_disabled got %b want 10", {cpu_run, bp_hit}); end
`endif
        step_clk();
        set_pc(32'h14); run_req = 1'b0;
        bp_wr_en = 1'b1; bp_wr_idx = 1'b1; bp_wr_addr = 32'h14; bp_wr_valid = 1'b1;
        #1;
        tests++; if ({cpu_run, bp_hit} !== 2'b10) begin fails++; $display("FAIL bp_same_cycle_write got %b want 10", {cpu_run, bp_hit}); end
        step_clk();
        bp_wr_en = 1'b0;
        tests++; if ({halted, trace_count} !== {1'b1, 5'd6}) begin fails++; $display("FAIL bp_end got %b/%0d want 1/6", halted, trace_count); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0;
        pc_in = '0; instr_in = '0; trace_rd = 1'b0;
        bp_wr_en = 1'b0; bp_wr_idx = '0; bp_wr_addr = '0; bp_wr_valid = 1'b0;
        test_reset();
        test_run_trace();
        test_step();
        test_full();
        test_reset_mid_run();
        test_breakpoint();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
